// File: rtl/multicycle_controller_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle ARM controller.
// MemReady is present only when CTRL_MEMWAIT_EN is defined.
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 2
);
  logic [31:12]          Instr;
  logic [3:0]            ALUFlags;
`ifdef CTRL_MEMWAIT_EN
  logic                  MemReady;
`endif
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic [1:0]            ResultSrc;
  logic [ALUCTRL_W-1:0]  ALUControl;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic                  RegWrite;

  // controller side
  modport slave (
    input  Instr, ALUFlags,
`ifdef CTRL_MEMWAIT_EN
    input  MemReady,
`endif
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
  );

  // datapath / stimulus side
  modport master (
    output Instr, ALUFlags,
`ifdef CTRL_MEMWAIT_EN
    output MemReady,
`endif
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore main FSM, ALU decoder and condition logic.
// Controls are registered on entry to each state; only reset and the memory
// wait handshake gate them combinationally.
// Optional: define CTRL_MEMWAIT_EN to add MemReady and stall FETCH/MEMREAD/MEMWRITE.
module multicycle_controller #(
  parameter int ALUCTRL_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  typedef struct packed {
    logic                 pcwrite;
    logic                 adrsrc;
    logic                 memwrite;
    logic                 irwrite;
    logic [1:0]           resultsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 alusrca;
    logic [1:0]           alusrcb;
    logic                 regwrite;
  } ctl_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);

  state_t               state, nxt;
  ctl_t                 ctl_q, ctl_n, ctl_o;
  logic [3:0]           flags;
  logic                 condexr, condexr_n, cond_ex;
  logic [ALUCTRL_W-1:0] alu_dec;
  logic                 no_write;
  logic [1:0]           flag_w;
  logic                 mem_rdy;

  logic [1:0] op;
  logic [3:0] cmd, cond;
  logic       ibit, sbit, ubit;

  assign op   = bus.Instr[27:26];
  assign ibit = bus.Instr[25];
  assign cmd  = bus.Instr[24:21];
  assign ubit = bus.Instr[23];
  assign sbit = bus.Instr[20];
  assign cond = bus.Instr[31:28];

  // register-field bits of the instruction are the datapath's business
  logic unused_instr;
  assign unused_instr = &{1'b0, bus.Instr[19:12]};

`ifdef CTRL_MEMWAIT_EN
  assign mem_rdy = bus.MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  // Per-state control word; ce is the latched condition for this instruction
  function automatic ctl_t state_ctl(state_t s, logic ce, logic ub,
                                     logic [ALUCTRL_W-1:0] ad, logic nw);
    ctl_t c;
    c = '0;
    c.alucontrol = ALU_ADD;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.pcwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      // PC+4 again, so R15 reads see PC+8
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      MEMADR: begin
        c.alusrcb    = 2'b01;
        c.alucontrol = ub ? ALU_ADD : ALU_SUB;
      end
      MEMREAD:  c.adrsrc = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = ce;
      end
      MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = ce;
      end
      EXECUTER: c.alucontrol = ad;
      EXECUTEI: begin
        c.alusrcb    = 2'b01;
        c.alucontrol = ad;
      end
      ALUWB:    c.regwrite = ce & ~nw;
      BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.pcwrite   = ce;
      end
      default: ;
    endcase
    return c;
  endfunction

  // ALU decoder: operation, register-write suppression and flag-write mask
  always_comb begin
    alu_dec  = ALU_ADD;
    no_write = 1'b0;
    flag_w   = 2'b00;
    case (cmd)
      4'b0100: begin alu_dec = ALU_ADD; flag_w = {sbit, sbit}; end
      4'b0010: begin alu_dec = ALU_SUB; flag_w = {sbit, sbit}; end
      4'b0000: begin alu_dec = ALU_AND; flag_w = {sbit, 1'b0}; end
      4'b1100: begin alu_dec = ALU_ORR; flag_w = {sbit, 1'b0}; end
      4'b1010: begin alu_dec = ALU_SUB; no_write = 1'b1; flag_w = 2'b11; end
      4'b0001: begin
        if (ALUCTRL_W == 3) begin
          alu_dec = ALU_EOR;
          flag_w  = {sbit, 1'b0};
        end else begin
          no_write = 1'b1;
        end
      end
      default: no_write = 1'b1;
    endcase
  end

  // ARM condition table against the registered flags
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next-state logic; memory states hold while memory is not ready
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    if (mem_rdy) nxt = DECODE;
      DECODE: begin
        case (op)
          2'b01:   nxt = MEMADR;
          2'b00:   nxt = ibit ? EXECUTEI : EXECUTER;
          2'b10:   nxt = BRANCH;
          default: nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = sbit ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_rdy) nxt = MEMWB;
      MEMWB:    nxt = FETCH;
      MEMWRITE: if (mem_rdy) nxt = FETCH;
      EXECUTER, EXECUTEI: nxt = ALUWB;
      ALUWB, BRANCH:      nxt = FETCH;
      default:  nxt = FETCH;
    endcase
  end

  // CondExR as it will be after this edge, so entry controls see the new value
  assign condexr_n = (state == DECODE) ? cond_ex : condexr;
  assign ctl_n     = state_ctl(nxt, condexr_n, ubit, alu_dec, no_write);

  // Main FSM: state, latched condition, flags and registered controls
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      flags   <= 4'b0000;
      condexr <= 1'b0;
      ctl_q   <= state_ctl(FETCH, 1'b0, ubit, alu_dec, no_write);
    end else begin
      state   <= nxt;
      condexr <= condexr_n;
      ctl_q   <= ctl_n;
      // flags commit only at the end of execute, after this instruction's condition
      if ((state == EXECUTER || state == EXECUTEI) && condexr) begin
        if (flag_w[1]) flags[3:2] <= bus.ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // Output gating: reset forces FETCH muxes with all write enables off
  always_comb begin
    ctl_o = ctl_q;
`ifdef CTRL_MEMWAIT_EN
    if (state == FETCH && !bus.MemReady) begin
      ctl_o.irwrite = 1'b0;
      ctl_o.pcwrite = 1'b0;
    end
`endif
    if (reset) begin
      ctl_o         = state_ctl(FETCH, 1'b0, ubit, alu_dec, no_write);
      ctl_o.pcwrite = 1'b0;
      ctl_o.irwrite = 1'b0;
    end
  end

  assign bus.PCWrite    = ctl_o.pcwrite;
  assign bus.AdrSrc     = ctl_o.adrsrc;
  assign bus.MemWrite   = ctl_o.memwrite;
  assign bus.IRWrite    = ctl_o.irwrite;
  assign bus.ResultSrc  = ctl_o.resultsrc;
  assign bus.ALUControl = ctl_o.alucontrol;
  assign bus.ALUSrcA    = ctl_o.alusrca;
  assign bus.ALUSrcB    = ctl_o.alusrcb;
  assign bus.RegWrite   = ctl_o.regwrite;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) & ~sbit, op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: ALUCTRL_W=2 and ALUCTRL_W=3 instances run
// the same instruction stream; expected per-cycle controls go through a scoreboard.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.ALUCTRL_W(2)) b2 ();
  multicycle_controller_if #(.ALUCTRL_W(3)) b3 ();

  assign b3.Instr    = b2.Instr;
  assign b3.ALUFlags = b2.ALUFlags;
`ifdef CTRL_MEMWAIT_EN
  assign b3.MemReady = b2.MemReady;
`endif

  multicycle_controller #(.ALUCTRL_W(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  multicycle_controller #(.ALUCTRL_W(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  // [16]RegWrite [15]PCWrite [14]AdrSrc [13]MemWrite [12]IRWrite [11:10]ResultSrc
  // [9:7]ALUControl [6]ALUSrcA [5:4]ALUSrcB [3:2]ImmSrc [1:0]RegSrc
  logic [16:0] act2, act3;
  assign act2 = {b2.RegWrite, b2.PCWrite, b2.AdrSrc, b2.MemWrite, b2.IRWrite, b2.ResultSrc,
                 1'b0, b2.ALUControl, b2.ALUSrcA, b2.ALUSrcB, b2.ImmSrc, b2.RegSrc};
  assign act3 = {b3.RegWrite, b3.PCWrite, b3.AdrSrc, b3.MemWrite, b3.IRWrite, b3.ResultSrc,
                 b3.ALUControl, b3.ALUSrcA, b3.ALUSrcB, b3.ImmSrc, b3.RegSrc};

  localparam logic [16:0] WE    = 17'h1B000;
  localparam logic [16:0] M_AD  = 17'h04000;
  localparam logic [16:0] M_RS  = 17'h00C00;
  localparam logic [16:0] M_AC  = 17'h00380;
  localparam logic [16:0] M_SA  = 17'h00040;
  localparam logic [16:0] M_SB  = 17'h00030;
  localparam logic [16:0] M_IMM = 17'h0000C;
  localparam logic [16:0] M_RGS = 17'h00003;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5,
                 S_ER = 6, S_EI = 7, S_AW = 8, S_BR = 9;

  typedef struct packed { logic [16:0] v; logic [16:0] m; } vm_t;
  typedef struct { vm_t a; vm_t b; string tag; } ent_t;

  ent_t sb[$];

  // Expected controls for one state, straight from the state output table
  function automatic vm_t model(input int st, input logic [31:0] ins, input logic ce,
                                input logic [2:0] ac, input logic nw);
    vm_t r;
    r.v = '0;
    r.m = WE | M_IMM;
    r.v[3:2] = ins[27:26];
    case (st)
      S_F:  begin r.v[15] = 1'b1; r.v[12] = 1'b1; r.v[6] = 1'b1; r.v[5:4] = 2'b10;
                  r.v[11:10] = 2'b10; r.m |= M_AD | M_SA | M_SB | M_AC | M_RS; end
      S_D:  begin r.v[6] = 1'b1; r.v[5:4] = 2'b10; r.v[11:10] = 2'b10;
                  r.m |= M_SA | M_SB | M_RS; end
      S_MA: begin r.v[5:4] = 2'b01; r.v[9:7] = ins[23] ? 3'd0 : 3'd1;
                  r.m |= M_SA | M_SB | M_AC; end
      S_MR: begin r.v[14] = 1'b1; r.m |= M_AD | M_RS; end
      S_MWB: begin r.v[11:10] = 2'b01; r.v[16] = ce; r.m |= M_RS; end
      S_MW: begin r.v[14] = 1'b1; r.v[13] = ce; r.v[1:0] = 2'b10;
                  r.m |= M_AD | M_RS | M_RGS; end
      S_ER: begin r.v[9:7] = ac; r.m |= M_SA | M_SB | M_AC; end
      S_EI: begin r.v[5:4] = 2'b01; r.v[9:7] = ac; r.m |= M_SA | M_SB | M_AC; end
      S_AW: begin r.v[16] = ce & ~nw; r.m |= M_RS; end
      S_BR: begin r.v[5:4] = 2'b01; r.v[11:10] = 2'b10; r.v[15] = ce; r.v[1:0] = 2'b01;
                  r.m |= M_SA | M_SB | M_AC | M_RS | M_RGS; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic ent_t mk(input string nm, input int st, input logic [31:0] ins,
                              input logic ce, input logic [2:0] a2, input logic nw2,
                              input logic [2:0] a3, input logic nw3);
    ent_t e;
    e.a   = model(st, ins, ce, a2, nw2);
    e.b   = model(st, ins, ce, a3, nw3);
    e.tag = $sformatf("%s.s%0d", nm, st);
    return e;
  endfunction

  // Pop one expectation per cycle and compare both instances at the negedge
  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ((act2 & e.a.m) !== (e.a.v & e.a.m)) begin
        miscompares++;
        $display("FAIL %s w2 got %05h exp %05h mask %05h", e.tag, act2 & e.a.m, e.a.v & e.a.m, e.a.m);
      end
      vectors++;
      if ((act3 & e.b.m) !== (e.b.v & e.b.m)) begin
        miscompares++;
        $display("FAIL %s w3 got %05h exp %05h mask %05h", e.tag, act3 & e.b.m, e.b.v & e.b.m, e.b.m);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one instruction from FETCH and queue its expected state sequence
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic [3:0] fl,
                           input logic ce, input logic [2:0] a2, input logic nw2,
                           input logic [2:0] a3, input logic nw3);
    b2.Instr    = ins[31:12];
    b2.ALUFlags = fl;
    sb.push_back(mk(nm, S_F, ins, ce, a2, nw2, a3, nw3));
    sb.push_back(mk(nm, S_D, ins, ce, a2, nw2, a3, nw3));
    case (ins[27:26])
      2'b01: begin
        sb.push_back(mk(nm, S_MA, ins, ce, a2, nw2, a3, nw3));
        if (ins[20]) begin
          sb.push_back(mk(nm, S_MR, ins, ce, a2, nw2, a3, nw3));
          sb.push_back(mk(nm, S_MWB, ins, ce, a2, nw2, a3, nw3));
        end else begin
          sb.push_back(mk(nm, S_MW, ins, ce, a2, nw2, a3, nw3));
        end
      end
      2'b00: begin
        sb.push_back(mk(nm, ins[25] ? S_EI : S_ER, ins, ce, a2, nw2, a3, nw3));
        sb.push_back(mk(nm, S_AW, ins, ce, a2, nw2, a3, nw3));
      end
      2'b10: sb.push_back(mk(nm, S_BR, ins, ce, a2, nw2, a3, nw3));
      default: ;
    endcase
    drain();
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] fl,
                     input logic ce, input logic [2:0] ac, input logic nw);
    run_instr(nm, ins, fl, ce, ac, nw, ac, nw);
  endtask

  task automatic test_reset();
    vm_t r;
    reset       = 1'b1;
    b2.Instr    = '0;
    b2.ALUFlags = '0;
    r = model(S_F, 32'h0, 1'b0, 3'd0, 1'b0);
    r.v[15] = 1'b0;
    r.v[12] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ((act2 & r.m) !== (r.v & r.m)) begin
        miscompares++;
        $display("FAIL reset_hold%0d got %05h exp %05h", i, act2 & r.m, r.v & r.m);
      end
      @(posedge clk);
    end
    #1 reset = 1'b0;
    // flags cleared by reset: EQ fails, NE passes
    run("BEQ0", 32'h0A000002, 4'h0, 1'b0, 3'd0, 1'b0);
    run("BNE0", 32'h1A000002, 4'h0, 1'b1, 3'd0, 1'b0);
  endtask

  task automatic test_dp_imm();
    run("ADDI", 32'hE2810005, 4'h0, 1'b1, 3'd0, 1'b0);
  endtask

  task automatic test_mem();
    run("LDR", 32'hE5912004, 4'h0, 1'b1, 3'd0, 1'b0);
    run("STR", 32'hE5812004, 4'h0, 1'b1, 3'd0, 1'b0);
    run("LDRU0", 32'hE5112004, 4'h0, 1'b1, 3'd0, 1'b0);
  endtask

  task automatic test_cmp_branch();
    run("CMP", 32'hE3500000, 4'b0100, 1'b1, 3'd1, 1'b1);
    run("BEQ", 32'h0A000002, 4'h0, 1'b1, 3'd0, 1'b0);
    run("BNE", 32'h1A000002, 4'h0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_cond_fail();
    run("CMPz", 32'hE3500000, 4'b0000, 1'b1, 3'd1, 1'b1);
    run("ADDSEQ", 32'h02910005, 4'b1001, 1'b0, 3'd0, 1'b0);
    run("BMI0", 32'h4A000002, 4'h0, 1'b0, 3'd0, 1'b0);
    run("BVS0", 32'h6A000002, 4'h0, 1'b0, 3'd0, 1'b0);
    run("ADDS", 32'hE2910005, 4'b1001, 1'b1, 3'd0, 1'b0);
    run("BMI1", 32'h4A000002, 4'h0, 1'b1, 3'd0, 1'b0);
    // ORRS writes N,Z only: C,V keep 0,1
    run("ORRS", 32'hE3910005, 4'b0110, 1'b1, 3'd3, 1'b0);
    run("BVS1", 32'h6A000002, 4'h0, 1'b1, 3'd0, 1'b0);
    run("BEQ1", 32'h0A000002, 4'h0, 1'b1, 3'd0, 1'b0);
    run("BMI2", 32'h4A000002, 4'h0, 1'b0, 3'd0, 1'b0);
    run("BCS0", 32'h2A000002, 4'h0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins;
    ins = 32'hE5812004;
    b2.Instr = ins[31:12];
    sb.push_back(mk("STRr", S_F, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    sb.push_back(mk("STRr", S_D, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    sb.push_back(mk("STRr", S_MA, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    drain();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ((act2 & WE) !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_in_memwrite enables got %05h exp 00000", act2 & WE);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    // Z was 1 before reset; cleared flags make EQ fail
    run("BEQr", 32'h0A000002, 4'h0, 1'b0, 3'd0, 1'b0);
    run("BNEr", 32'h1A000002, 4'h0, 1'b1, 3'd0, 1'b0);
  endtask

  task automatic test_eor();
    run_instr("EOR", 32'hE0210002, 4'h0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0);
  endtask

`ifdef CTRL_MEMWAIT_EN
  task automatic test_memwait();
    ent_t        e;
    logic [31:0] ins;
    ins = 32'hE2810005;
    b2.Instr = ins[31:12];
    b2.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = mk("FSTALL", S_F, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      e.a.v[15] = 1'b0; e.a.v[12] = 1'b0;
      e.b.v[15] = 1'b0; e.b.v[12] = 1'b0;
      sb.push_back(e);
      drain();
    end
    b2.MemReady = 1'b1;
    run("ADDw", ins, 4'h0, 1'b1, 3'd0, 1'b0);
    ins = 32'hE5812004;
    b2.Instr = ins[31:12];
    sb.push_back(mk("STRw", S_F, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    sb.push_back(mk("STRw", S_D, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    sb.push_back(mk("STRw", S_MA, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    drain();
    b2.MemReady = 1'b0;
    sb.push_back(mk("MWSTALL", S_MW, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    sb.push_back(mk("MWSTALL", S_MW, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    drain();
    b2.MemReady = 1'b1;
    sb.push_back(mk("STRw", S_MW, ins, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0));
    drain();
    run("BNEw", 32'h1A000002, 4'h0, 1'b1, 3'd0, 1'b0);
  endtask
`endif

  initial begin
`ifdef CTRL_MEMWAIT_EN
    b2.MemReady = 1'b1;
`endif
    test_reset();
    test_dp_imm();
    test_mem();
    test_cmp_branch();
    test_cond_fail();
    test_reset_mid();
    test_eor();
`ifdef CTRL_MEMWAIT_EN
    test_memwait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle ARM datapath. It is the successor to the single-cycle controller and uses the same instruction field and condition-flag interface. A Moore main FSM sequences each instruction over 3–5 cycles, and an ALU decoder drives the ALU. Condition logic holds the NZCV flags and the latched condition result that gates every architectural write. It sits between the instruction register and the multicycle datapath; the datapath muxes are driven directly from its outputs.

Parameters:
ALUCTRL_W, 2, width of ALUControl. 2 supports ADD/SUB/AND/ORR. 3 additionally supports EOR.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
Instr  in  20  Instr[31:12] from the instruction register; stable from DECODE through end of the instruction
ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
ResultSrc  out  2  result mux: 00 ALUOut register, 01 Data register, 10 ALU result
ALUControl  out  ALUCTRL_W  00 ADD, 01 SUB, 10 AND, 11 ORR; 100 EOR when ALUCTRL_W=3
ALUSrcA  out  1  0=register RD1, 1=PC
ALUSrcB  out  2  00 register RD2, 01 ExtImm, 10 constant 4
ImmSrc  out  2  equals Instr[27:26]
RegSrc  out  2  [0]=1 for branch (RA1 selects R15); [1]=1 for STR (RA2 selects Rd)
RegWrite  out  1  register file write enable

Behaviour:
- Reset is synchronous and active-high. Clock port is clk; reset port is reset.
- On reset: state<=FETCH, Flags<=0000, CondExR<=0.
- While reset is high: PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH values.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op(Instr[27:26])=01 -> MEMADR; op=00 with I(Instr[25])=0 -> EXECUTER; op=00 with I=1 -> EXECUTEI; op=10 -> BRANCH; op=11 -> FETCH (NOP).
  - MEMADR: L(Instr[20])=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH. EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH->FETCH.
- Per-state outputs (unlisted signals are 0 or don't-care):
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This produces PC+8 for R15 reads.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. If U(Instr[23])=0, SUB.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondExR.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondExR.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, decoded ALUControl.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, decoded ALUControl.
  - ALUWB: ResultSrc=00, RegWrite=CondExR & ~NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExR.
- ALU decode uses cmd=Instr[24:21] and S=Instr[20]:
  - ADD 0100, SUB 0010, AND 0000, ORR 1100.
  - CMP 1010: SUB with NoWrite=1 and FlagW=11 regardless of S.
  - EOR 0001: decoded only when ALUCTRL_W=3.
  - Any other cmd: ALUControl=ADD, NoWrite=1, FlagW=00. Net effect is a NOP.
  - Otherwise FlagW[1]=S and FlagW[0]=S & (ADD|SUB).
- Condition logic:
  - CondEx is evaluated from Instr[31:28] against registered Flags, using the standard ARM table (0000 EQ … 1110 AL).
  - 1111 evaluates false.
  - CondExR is loaded at the end of DECODE and held until the next DECODE.
  - Flags[3:2]<=ALUFlags[3:2] if FlagW[1]&CondExR; Flags[1:0]<=ALUFlags[1:0] if FlagW[0]&CondExR.
  - Flags update only at the end of EXECUTER/EXECUTEI. This keeps the condition of the current instruction from seeing its own flag result.
- Reset asserted in any state: returns to FETCH on the next edge. No write enable is asserted in that cycle.
- Latency: branch 3 cycles, data-processing 4, STR 4, LDR 5.

Optional Feature:
CTRL_MEMWAIT_EN.
- Defined: adds input port MemReady (1 bit), placed after ALUFlags.
  - FETCH, MEMREAD and MEMWRITE hold their state while MemReady=0.
  - During a FETCH stall, IRWrite and PCWrite are 0; they assert only in the cycle MemReady=1.
  - During a MEMWRITE stall, MemWrite is held at CondExR.
- Undefined: no MemReady port; memory is always single-cycle.

Test Plan:
- Reset held 2 cycles, then released, Instr=E2810005 (ADD R0,R1,#5) -> FETCH, DECODE, EXECUTEI, ALUWB. RegWrite=1 only in ALUWB. Next state FETCH. ALUControl=00 in EXECUTEI.
- LDR E5912004 -> 5-cycle sequence ending MEMWB with ResultSrc=01, RegWrite=1. STR E5812004 -> MEMWRITE with MemWrite=1, RegSrc=10, 4 cycles.
- CMP E3500000 with ALUFlags=0100 -> Flags=0100 after EXECUTEI. ALUWB has RegWrite=0. Following BEQ 0A000002 -> BRANCH with PCWrite=1. BNE 1A000002 -> PCWrite=0 in BRANCH.
- ADDS with cond EQ and Flags Z=0 -> no RegWrite in ALUWB. Flags unchanged even though ALUFlags=1001.
- Reset asserted during MEMWRITE -> MemWrite=0 that cycle. State=FETCH next cycle. Flags=0000.
- ALUCTRL_W=3 with EOR E0210002 -> ALUControl=100. ALUCTRL_W=2 with the same instruction -> RegWrite=0 (NOP). With CTRL_MEMWAIT_EN and MemReady=0 for 3 cycles in FETCH -> state holds and IRWrite=0 until MemReady=1.
